// File: rtl/ysyx_22050133_axi_rr_arbiter_if.sv
// AXI4 bundle carrying N_PORTS lanes side by side (lane i in slice i of every field).
// The arbiter takes a multi-lane slave view upstream and a single-lane master view downstream.
interface ysyx_22050133_axi_rr_arbiter_if #(
  parameter int unsigned N_PORTS    = 1,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 4
);
  localparam int unsigned StrbWidth = DATA_WIDTH / 8;

  logic [N_PORTS-1:0]            aw_valid, aw_ready;
  logic [N_PORTS*ID_WIDTH-1:0]   aw_id;
  logic [N_PORTS*ADDR_WIDTH-1:0] aw_addr;
  logic [N_PORTS*8-1:0]          aw_len;
  logic [N_PORTS*3-1:0]          aw_size;
  logic [N_PORTS*2-1:0]          aw_burst;

  logic [N_PORTS-1:0]            w_valid, w_ready, w_last;
  logic [N_PORTS*DATA_WIDTH-1:0] w_data;
  logic [N_PORTS*StrbWidth-1:0]  w_strb;

  logic [N_PORTS-1:0]            b_valid, b_ready;
  logic [N_PORTS*ID_WIDTH-1:0]   b_id;
  logic [N_PORTS*2-1:0]          b_resp;

  logic [N_PORTS-1:0]            ar_valid, ar_ready;
  logic [N_PORTS*ID_WIDTH-1:0]   ar_id;
  logic [N_PORTS*ADDR_WIDTH-1:0] ar_addr;
  logic [N_PORTS*8-1:0]          ar_len;
  logic [N_PORTS*3-1:0]          ar_size;
  logic [N_PORTS*2-1:0]          ar_burst;

  logic [N_PORTS-1:0]            r_valid, r_ready, r_last;
  logic [N_PORTS*ID_WIDTH-1:0]   r_id;
  logic [N_PORTS*DATA_WIDTH-1:0] r_data;
  logic [N_PORTS*2-1:0]          r_resp;

  modport master (
    output aw_valid, aw_id, aw_addr, aw_len, aw_size, aw_burst, input aw_ready,
    output w_valid, w_data, w_strb, w_last, input w_ready,
    input b_valid, b_id, b_resp, output b_ready,
    output ar_valid, ar_id, ar_addr, ar_len, ar_size, ar_burst, input ar_ready,
    input r_valid, r_id, r_data, r_resp, r_last, output r_ready
  );

  modport slave (
    input aw_valid, aw_id, aw_addr, aw_len, aw_size, aw_burst, output aw_ready,
    input w_valid, w_data, w_strb, w_last, output w_ready,
    output b_valid, b_id, b_resp, input b_ready,
    input ar_valid, ar_id, ar_addr, ar_len, ar_size, ar_burst, output ar_ready,
    output r_valid, r_id, r_data, r_resp, r_last, input r_ready
  );
endinterface

// File: rtl/ysyx_22050133_axi_rr_arbiter.sv
// Round-robin N:1 AXI4 arbiter with independent read and write ownership.
// Grants are registered; once granted, all channel routing is combinational.
module ysyx_22050133_axi_rr_arbiter #(
  parameter int unsigned NUM_MASTERS    = 2,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_ID_WIDTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  ysyx_22050133_axi_rr_arbiter_if.slave  s_axi,
  ysyx_22050133_axi_rr_arbiter_if.master m_axi,
  output logic [NUM_MASTERS-1:0]        rd_grant_o,
  output logic [NUM_MASTERS-1:0]        wr_grant_o
);
  localparam int unsigned DW    = AXI_DATA_WIDTH;
  localparam int unsigned AW    = AXI_ADDR_WIDTH;
  localparam int unsigned IW    = AXI_ID_WIDTH;
  localparam int unsigned SW    = DW / 8;
  localparam int unsigned IdxW  = $clog2(NUM_MASTERS);

  typedef enum logic [1:0] {RdIdle, RdAddr, RdData} rd_state_e;
  typedef enum logic [1:0] {WrIdle, WrAddr, WrData, WrResp} wr_state_e;

  rd_state_e           rd_state_q;
  wr_state_e           wr_state_q;
  logic [IdxW-1:0]     rd_idx_q, wr_idx_q, rd_ptr_q, wr_ptr_q;

  // First requester at or above ptr, wrapping; only consulted when some bit of req is set.
  function automatic logic [IdxW-1:0] rr_pick(input logic [NUM_MASTERS-1:0] req,
                                              input logic [IdxW-1:0] ptr);
    logic [IdxW-1:0] sel;
    logic            found;
    int unsigned     c;
    sel   = ptr;
    found = 1'b0;
    for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
      c = (32'(ptr) + k) % NUM_MASTERS;
      if (!found && req[c]) begin
        sel   = IdxW'(c);
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  function automatic logic [IdxW-1:0] rr_next(input logic [IdxW-1:0] idx);
    return (idx == IdxW'(NUM_MASTERS - 1)) ? '0 : idx + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state_q <= RdIdle;
      rd_idx_q   <= '0;
      rd_ptr_q   <= '0;
      rd_grant_o <= '0;
    end else begin
      unique case (rd_state_q)
        RdIdle: if (|s_axi.ar_valid) begin
          rd_idx_q   <= rr_pick(s_axi.ar_valid, rd_ptr_q);
          rd_grant_o <= NUM_MASTERS'(1) << rr_pick(s_axi.ar_valid, rd_ptr_q);
          rd_state_q <= RdAddr;
        end
        RdAddr: if (m_axi.ar_valid[0] && m_axi.ar_ready[0]) rd_state_q <= RdData;
        RdData: if (m_axi.r_valid[0] && m_axi.r_ready[0] && m_axi.r_last[0]) begin
          rd_state_q <= RdIdle;
          rd_grant_o <= '0;
          rd_ptr_q   <= rr_next(rd_idx_q);
        end
        default: rd_state_q <= RdIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state_q <= WrIdle;
      wr_idx_q   <= '0;
      wr_ptr_q   <= '0;
      wr_grant_o <= '0;
    end else begin
      unique case (wr_state_q)
        WrIdle: if (|s_axi.aw_valid) begin
          wr_idx_q   <= rr_pick(s_axi.aw_valid, wr_ptr_q);
          wr_grant_o <= NUM_MASTERS'(1) << rr_pick(s_axi.aw_valid, wr_ptr_q);
          wr_state_q <= WrAddr;
        end
        WrAddr: if (m_axi.aw_valid[0] && m_axi.aw_ready[0]) wr_state_q <= WrData;
        WrData: if (m_axi.w_valid[0] && m_axi.w_ready[0] && m_axi.w_last[0]) wr_state_q <= WrResp;
        WrResp: if (m_axi.b_valid[0] && m_axi.b_ready[0]) begin
          wr_state_q <= WrIdle;
          wr_grant_o <= '0;
          wr_ptr_q   <= rr_next(wr_idx_q);
        end
        default: wr_state_q <= WrIdle;
      endcase
    end
  end

  // Read routing: everything not owned by the active phase stays at zero.
  always_comb begin
    m_axi.ar_valid = '0;
    m_axi.ar_id    = '0;
    m_axi.ar_addr  = '0;
    m_axi.ar_len   = '0;
    m_axi.ar_size  = '0;
    m_axi.ar_burst = '0;
    m_axi.r_ready  = '0;
    s_axi.ar_ready = '0;
    s_axi.r_valid  = '0;
    s_axi.r_id     = '0;
    s_axi.r_data   = '0;
    s_axi.r_resp   = '0;
    s_axi.r_last   = '0;
    if (rd_state_q == RdAddr) begin
      m_axi.ar_valid           = s_axi.ar_valid[rd_idx_q];
      m_axi.ar_id              = s_axi.ar_id[rd_idx_q*IW +: IW];
      m_axi.ar_addr            = s_axi.ar_addr[rd_idx_q*AW +: AW];
      m_axi.ar_len             = s_axi.ar_len[rd_idx_q*8 +: 8];
      m_axi.ar_size            = s_axi.ar_size[rd_idx_q*3 +: 3];
      m_axi.ar_burst           = s_axi.ar_burst[rd_idx_q*2 +: 2];
      s_axi.ar_ready[rd_idx_q] = m_axi.ar_ready[0];
    end
    if (rd_state_q == RdData) begin
      m_axi.r_ready                  = s_axi.r_ready[rd_idx_q];
      s_axi.r_valid[rd_idx_q]        = m_axi.r_valid[0];
      s_axi.r_id[rd_idx_q*IW +: IW]  = m_axi.r_id;
      s_axi.r_data[rd_idx_q*DW +: DW] = m_axi.r_data;
      s_axi.r_resp[rd_idx_q*2 +: 2]  = m_axi.r_resp;
      s_axi.r_last[rd_idx_q]         = m_axi.r_last[0];
    end
  end

  always_comb begin
    m_axi.aw_valid = '0;
    m_axi.aw_id    = '0;
    m_axi.aw_addr  = '0;
    m_axi.aw_len   = '0;
    m_axi.aw_size  = '0;
    m_axi.aw_burst = '0;
    m_axi.w_valid  = '0;
    m_axi.w_data   = '0;
    m_axi.w_strb   = '0;
    m_axi.w_last   = '0;
    m_axi.b_ready  = '0;
    s_axi.aw_ready = '0;
    s_axi.w_ready  = '0;
    s_axi.b_valid  = '0;
    s_axi.b_id     = '0;
    s_axi.b_resp   = '0;
    if (wr_state_q == WrAddr) begin
      m_axi.aw_valid           = s_axi.aw_valid[wr_idx_q];
      m_axi.aw_id              = s_axi.aw_id[wr_idx_q*IW +: IW];
      m_axi.aw_addr            = s_axi.aw_addr[wr_idx_q*AW +: AW];
      m_axi.aw_len             = s_axi.aw_len[wr_idx_q*8 +: 8];
      m_axi.aw_size            = s_axi.aw_size[wr_idx_q*3 +: 3];
      m_axi.aw_burst           = s_axi.aw_burst[wr_idx_q*2 +: 2];
      s_axi.aw_ready[wr_idx_q] = m_axi.aw_ready[0];
    end
    if (wr_state_q == WrData) begin
      m_axi.w_valid           = s_axi.w_valid[wr_idx_q];
      m_axi.w_data            = s_axi.w_data[wr_idx_q*DW +: DW];
      m_axi.w_strb            = s_axi.w_strb[wr_idx_q*SW +: SW];
      m_axi.w_last            = s_axi.w_last[wr_idx_q];
      s_axi.w_ready[wr_idx_q] = m_axi.w_ready[0];
    end
    if (wr_state_q == WrResp) begin
      m_axi.b_ready                 = s_axi.b_ready[wr_idx_q];
      s_axi.b_valid[wr_idx_q]       = m_axi.b_valid[0];
      s_axi.b_id[wr_idx_q*IW +: IW] = m_axi.b_id;
      s_axi.b_resp[wr_idx_q*2 +: 2] = m_axi.b_resp;
    end
  end
endmodule

// File: tb/tb_ysyx_22050133_axi_rr_arbiter.sv
// Directed bench for the round-robin AXI arbiter, four upstream masters.
module tb_ysyx_22050133_axi_rr_arbiter;
  localparam int unsigned NM = 4;

  logic          clk;
  logic          rst;
  logic [NM-1:0] rd_grant, wr_grant;
  int            n_tests = 0;
  int            n_fail  = 0;

  ysyx_22050133_axi_rr_arbiter_if #(.N_PORTS(NM)) s_if ();
  ysyx_22050133_axi_rr_arbiter_if #(.N_PORTS(1))  m_if ();

  ysyx_22050133_axi_rr_arbiter #(.NUM_MASTERS(NM)) dut (
    .clk        (clk),
    .rst        (rst),
    .s_axi      (s_if.slave),
    .m_axi      (m_if.master),
    .rd_grant_o (rd_grant),
    .wr_grant_o (wr_grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for a read grant, then runs one read burst of the given beat count.
  task automatic rd_txn(input int exp_m, input logic [31:0] exp_addr, input int beats);
    int w = 0;
    while (rd_grant == '0 && w < 8) begin
      tick();
      w++;
    end
    check("rd_grant", 64'(rd_grant), 64'(4'b0001 << exp_m));
    check("ar_addr", 64'(m_if.ar_addr), 64'(exp_addr));
    check("ar_valid", 64'(m_if.ar_valid), 64'd1);
    m_if.ar_ready = 1'b1;
    #1 check("ar_ready_route", 64'(s_if.ar_ready), 64'(4'b0001 << exp_m));
    tick();
    for (int b = 0; b < beats; b++) begin
      m_if.r_valid = 1'b1;
      m_if.r_data  = 64'hD000 + 64'(b);
      m_if.r_id    = 4'h3;
      m_if.r_last  = (b == beats - 1);
      #1;
      check("r_valid_route", 64'(s_if.r_valid), 64'(4'b0001 << exp_m));
      check("r_data_route", s_if.r_data[exp_m*64 +: 64], 64'hD000 + 64'(b));
      check("ar_ready_blocked", 64'(s_if.ar_ready), 64'd0);
      tick();
    end
    m_if.r_valid  = 1'b0;
    m_if.r_last   = 1'b0;
    m_if.ar_ready = 1'b0;
    #1 check("rd_bubble", 64'(rd_grant), 64'd0);
  endtask

  task automatic wr_txn(input int exp_m, input logic [31:0] exp_addr, input int beats);
    int w = 0;
    while (wr_grant == '0 && w < 8) begin
      tick();
      w++;
    end
    check("wr_grant", 64'(wr_grant), 64'(4'b0001 << exp_m));
    check("aw_addr", 64'(m_if.aw_addr), 64'(exp_addr));
    check("aw_len", 64'(m_if.aw_len), 64'(beats - 1));
    m_if.aw_ready = 1'b1;
    #1 check("aw_ready_route", 64'(s_if.aw_ready), 64'(4'b0001 << exp_m));
    tick();
    m_if.aw_ready = 1'b0;
    s_if.aw_valid[exp_m] = 1'b0;
    m_if.w_ready = 1'b1;
    for (int b = 0; b < beats; b++) begin
      s_if.w_valid[exp_m] = 1'b1;
      s_if.w_data[exp_m*64 +: 64] = 64'hA000 + 64'(b);
      s_if.w_last[exp_m] = (b == beats - 1);
      #1;
      check("w_valid_fwd", 64'(m_if.w_valid), 64'd1);
      check("w_data_fwd", m_if.w_data, 64'hA000 + 64'(b));
      check("w_strb_fwd", 64'(m_if.w_strb), 64'hFF);
      check("w_ready_route", 64'(s_if.w_ready), 64'(4'b0001 << exp_m));
      tick();
    end
    s_if.w_valid = '0;
    s_if.w_last  = '0;
    m_if.w_ready = 1'b0;
    m_if.b_valid = 1'b1;
    m_if.b_resp  = 2'b00;
    m_if.b_id    = 4'h5;
    #1;
    check("b_valid_route", 64'(s_if.b_valid), 64'(4'b0001 << exp_m));
    check("b_id_route", 64'(s_if.b_id[exp_m*4 +: 4]), 64'h5);
    check("wr_grant_held", 64'(wr_grant), 64'(4'b0001 << exp_m));
    tick();
    m_if.b_valid = 1'b0;
    #1 check("wr_grant_release", 64'(wr_grant), 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    s_if.aw_valid = '0; s_if.aw_id = '0; s_if.aw_len = '0; s_if.aw_size = '0;
    s_if.aw_burst = '0; s_if.aw_addr = {32'h8000, 32'h7000, 32'h6000, 32'h5000};
    s_if.w_valid = '0; s_if.w_data = '0; s_if.w_strb = '1; s_if.w_last = '0;
    s_if.b_ready = '1;
    s_if.ar_valid = '0; s_if.ar_id = '0; s_if.ar_len = '0; s_if.ar_size = '0;
    s_if.ar_burst = '0; s_if.ar_addr = {32'h4000, 32'h3000, 32'h2000, 32'h1000};
    s_if.r_ready = '1;
    m_if.aw_ready = '0; m_if.w_ready = '0; m_if.b_valid = '0; m_if.b_id = '0;
    m_if.b_resp = '0; m_if.ar_ready = '0; m_if.r_valid = '0; m_if.r_id = '0;
    m_if.r_data = '0; m_if.r_resp = '0; m_if.r_last = '0;
    tick();
    tick();

    // Reset state
    check("rst_rd_grant", 64'(rd_grant), 64'd0);
    check("rst_wr_grant", 64'(wr_grant), 64'd0);
    check("rst_m_ar_valid", 64'(m_if.ar_valid), 64'd0);
    check("rst_m_aw_valid", 64'(m_if.aw_valid), 64'd0);
    check("rst_s_r_valid", 64'(s_if.r_valid), 64'd0);
    check("rst_s_b_valid", 64'(s_if.b_valid), 64'd0);

    // Simultaneous reads from masters 0 and 1; one cycle before AR appears downstream
    rst = 1'b0;
    s_if.ar_valid = 4'b0011;
    #1 check("ar_latency", 64'(m_if.ar_valid), 64'd0);
    tick();
    rd_txn(0, 32'h1000, 2);
    s_if.ar_valid[0] = 1'b0;
    rd_txn(1, 32'h2000, 1);
    s_if.ar_valid = '0;

    // Reset during beat 3 of an 8-beat read (pointer is 2, so master 0 wins alone)
    s_if.ar_valid = 4'b0001;
    tick();
    check("abort_grant", 64'(rd_grant), 64'd1);
    m_if.ar_ready = 1'b1;
    tick();
    s_if.ar_valid = '0;
    m_if.ar_ready = 1'b0;
    for (int b = 0; b < 3; b++) begin
      m_if.r_valid = 1'b1;
      m_if.r_data  = 64'hE000 + 64'(b);
      if (b == 2) rst = 1'b1;
      tick();
    end
    check("abort_rd_grant", 64'(rd_grant), 64'd0);
    check("abort_s_r_valid", 64'(s_if.r_valid), 64'd0);
    check("abort_m_r_ready", 64'(m_if.r_ready), 64'd0);
    check("abort_m_ar_valid", 64'(m_if.ar_valid), 64'd0);
    rst = 1'b0;
    m_if.r_valid = 1'b0;
    // Pointer back at 0 picks master 1 over 3; a stale pointer of 2 would pick 3
    s_if.ar_valid = 4'b1010;
    rd_txn(1, 32'h2000, 1);
    s_if.ar_valid = 4'b1000;
    rd_txn(3, 32'h4000, 1);

    // All four request continuously: 0,1,2,3,0
    s_if.ar_valid = 4'b1111;
    rd_txn(0, 32'h1000, 2);
    rd_txn(1, 32'h2000, 2);
    rd_txn(2, 32'h3000, 2);
    rd_txn(3, 32'h4000, 2);
    rd_txn(0, 32'h1000, 2);
    s_if.ar_valid = '0;

    // Master 1 writes 4 beats
    s_if.aw_len[15:8] = 8'd3;
    s_if.aw_valid = 4'b0010;
    wr_txn(1, 32'h6000, 4);

    // Concurrent: master 0 reads 8 beats while master 1 writes 4 beats
    s_if.ar_len[7:0] = 8'd7;
    s_if.ar_valid = 4'b0001;
    s_if.aw_valid = 4'b0010;
    tick();
    check("conc_rd_grant", 64'(rd_grant), 64'b01);
    check("conc_wr_grant", 64'(wr_grant), 64'b10);
    check("conc_ar_len", 64'(m_if.ar_len), 64'd7);
    m_if.ar_ready = 1'b1;
    m_if.aw_ready = 1'b1;
    tick();
    s_if.ar_valid = '0;
    s_if.aw_valid = '0;
    m_if.ar_ready = 1'b0;
    m_if.aw_ready = 1'b0;
    m_if.w_ready  = 1'b1;
    for (int b = 0; b < 8; b++) begin
      m_if.r_valid = 1'b1;
      m_if.r_data  = 64'hC000 + 64'(b);
      m_if.r_last  = (b == 7);
      s_if.w_valid[1] = (b < 4);
      s_if.w_last[1]  = (b == 3);
      s_if.w_data[127:64] = 64'hB000 + 64'(b);
      m_if.b_valid = (b == 4);
      #1;
      check("conc_r_valid", 64'(s_if.r_valid), 64'b01);
      if (b < 4) check("conc_w_data", m_if.w_data, 64'hB000 + 64'(b));
      if (b <= 4) check("conc_wr_held", 64'(wr_grant), 64'b10);
      else check("conc_wr_done", 64'(wr_grant), 64'd0);
      tick();
    end
    m_if.r_valid = 1'b0;
    m_if.r_last  = 1'b0;
    m_if.b_valid = 1'b0;
    #1 check("conc_rd_done", 64'(rd_grant), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ysyx_22050133_axi_rr_arbiter.md
YSYX_22050133_AXI_RR_ARBITER -- requirements
Module: ysyx_22050133_axi_rr_arbiter

Interface
REQ-001 SHALL have parameter NUM_MASTERS, default 2, number of upstream AXI masters (2..8).
REQ-002 SHALL have parameter AXI_DATA_WIDTH, default 64, data bus width.
REQ-003 SHALL have parameter AXI_ADDR_WIDTH, default 32, address width.
REQ-004 SHALL have parameter AXI_ID_WIDTH, default 4, ID width.
REQ-005 SHALL have port clk, input, 1, clock, all logic on rising edge.
REQ-006 SHALL have port rst, input, 1, reset, synchronous, active-high.
REQ-007 SHALL have, per slave-side channel field X of AW/W/B/AR/R (valid, ready, id, addr, len, size, burst, data, strb, last, resp), port s_axi_X, NUM_MASTERS*width, master i in slice i.
REQ-008 SHALL have master-side ports m_axi_X, one AXI4 interface, same field set and widths.
REQ-009 SHALL have port rd_grant_o, output, NUM_MASTERS, one-hot read owner, 0 when idle.
REQ-010 SHALL have port wr_grant_o, output, NUM_MASTERS, one-hot write owner, 0 when idle.

Function
REQ-011 SHALL arbitrate read (AR/R) and write (AW/W/B) paths independently and concurrently.
REQ-012 SHALL use read FSM RD_IDLE -> RD_ADDR -> RD_DATA -> RD_IDLE.
REQ-013 SHALL, in RD_IDLE with any s_axi_ar_valid set, register round-robin winner into rd_grant_o and enter RD_ADDR next cycle; no request -> stay.
REQ-014 SHALL, in RD_ADDR, forward winner's AR fields to m_axi_ar_*, return m_axi_ar_ready to winner only; on handshake enter RD_DATA.
REQ-015 SHALL, in RD_DATA, route m_axi_r_* to winner, m_axi_r_ready from winner; on r_valid&r_ready&r_last return to RD_IDLE.
REQ-016 SHALL use write FSM WR_IDLE -> WR_ADDR -> WR_DATA -> WR_RESP -> WR_IDLE; grant selection on s_axi_aw_valid as REQ-013.
REQ-017 SHALL leave WR_ADDR on AW handshake, WR_DATA on W handshake with w_last, WR_RESP on B handshake.
REQ-018 SHALL hold grant for the whole transaction; no preemption mid-burst.
REQ-019 SHALL implement round-robin: per-path pointer; priority starts at pointer, ascending index mod NUM_MASTERS; on transaction completion pointer = winner index + 1 (wraps NUM_MASTERS-1 -> 0).
REQ-020 SHALL drive ready/valid/data/id/resp/last = 0 to every non-granted master and on all master-side valids when idle.
REQ-021 SHALL add exactly one cycle latency from s_axi_*_valid (idle) to m_axi_*_valid; all forwarding after grant is combinational.
REQ-022 SHALL let a master withdraw nothing: requests sampled once; valid dropped before AR/AW handshake is a protocol violation, behaviour undefined.
REQ-023 SHALL, on completion and new request in same cycle, go idle first; new grant registered next cycle (one idle bubble).
REQ-024 SHALL allow same master to own read and write paths simultaneously.
REQ-025 SHALL pass id unmodified; no ID remapping.

Reset
REQ-026 SHALL, while rst high at a clock edge, set both FSMs to IDLE, both pointers to 0, grants to 0.
REQ-027 SHALL, during and after reset until a grant, drive all m_axi valids, m_axi ready outputs and all s_axi outputs to 0.
REQ-028 SHALL abort any in-flight transaction on reset mid-burst; no completion sent upstream.

Verification
REQ-029 Masters 0 and 1 assert AR (addr 0x1000, 0x2000) in same cycle, pointer 0 -> master 0 granted, m_axi_ar_addr=0x1000 one cycle later; after r_last, master 1 granted, addr 0x2000.
REQ-030 NUM_MASTERS=4, all four request reads continuously -> grant order 0,1,2,3,0 each after one burst.
REQ-031 Master 1 write len=3 (4 beats, strb 0xFF) -> 4 W beats forwarded, grant held through B resp=0, wr_grant_o returns 0 after B handshake.
REQ-032 Master 0 read burst len=7 while master 1 writes -> both proceed concurrently, rd_grant_o=0b01, wr_grant_o=0b10.
REQ-033 rst asserted during beat 3 of 8-beat read -> next cycle all outputs 0, pointer 0, new AR from master 1 granted normally.
REQ-034 Non-granted master sees r_valid=0 and ar_ready=0 throughout other master's burst, even when m_axi_ar_ready=1.
